// File: rtl/asl_pkg.sv
// Shared constants and types for the ASL classifier result writer.
// Holds the AHB transfer encodings, display register offsets and write FSM states.
package asl_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;

  localparam logic [31:0] SSD_DATA_OFS = 32'h0000_0000;
  localparam logic [31:0] SSD_DONE_OFS = 32'h0000_0004;

  localparam logic [4:0]  CLASS_INVALID = 5'd31;
  localparam int unsigned NUM_CLASSES   = 24;

  typedef enum logic [2:0] {
    COLLECT,
    A0,
    D0,
    A1,
    D1
  } wr_state_t;

endpackage

// File: rtl/asl_argmax.sv
// Streaming argmax over one frame of signed scores.
// Reports the winning index (or the invalid code) combinationally on the closing beat.
module asl_argmax #(
  parameter int unsigned              NUM_CLASSES = 24,
  parameter int unsigned              SCORE_W     = 16,
  parameter logic signed [SCORE_W-1:0] CONF_THRESH = '0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      beat_i,
  input  logic signed [SCORE_W-1:0] score_i,
  input  logic                      last_i,
  output logic                      frame_done_o,
  output logic [4:0]                result_o,
  output logic                      count_err_o
);
  import asl_pkg::*;

  localparam logic [4:0] IdxSat  = 5'd31;
  localparam logic [4:0] LastIdx = 5'(NUM_CLASSES - 1);

  logic [4:0]                idx_q, idx_d;
  logic [4:0]                max_idx_q, max_idx_d;
  logic signed [SCORE_W-1:0] max_q, max_d;

  always_comb begin
    idx_d        = idx_q;
    max_d        = max_q;
    max_idx_d    = max_idx_q;
    frame_done_o = 1'b0;
    count_err_o  = 1'b0;
    if (beat_i) begin
      if (idx_q == 5'd0) begin
        max_d     = score_i;
        max_idx_d = 5'd0;
      end else if (idx_q != IdxSat && score_i > max_q) begin
        // Strict compare keeps the lower index on ties.
        max_d     = score_i;
        max_idx_d = idx_q;
      end
      if (idx_q != IdxSat) begin
        idx_d = idx_q + 5'd1;
      end
      if (last_i) begin
        frame_done_o = 1'b1;
        count_err_o  = (idx_q != LastIdx);
        idx_d        = 5'd0;
      end
    end
    result_o = (count_err_o || (max_d < CONF_THRESH)) ? CLASS_INVALID : max_idx_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q     <= 5'd0;
      max_idx_q <= 5'd0;
      max_q     <= {1'b1, {(SCORE_W-1){1'b0}}};
    end else begin
      idx_q     <= idx_d;
      max_idx_q <= max_idx_d;
      max_q     <= max_d;
    end
  end

endmodule

// File: rtl/asl_result_writer.sv
// Argmax result writer: collects a frame of class scores, then posts the winning class and a
// done flag to the seven-segment display block with two single AHB-Lite writes.
module asl_result_writer #(
  parameter int unsigned               NUM_CLASSES = 24,
  parameter int unsigned               SCORE_W     = 16,
  parameter logic signed [SCORE_W-1:0] CONF_THRESH = '0,
  parameter logic [31:0]               BASE_ADDR   = 32'hC000_0000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      score_valid_i,
  input  logic signed [SCORE_W-1:0] score_data_i,
  input  logic                      score_last_i,
  output logic                      score_ready_o,
  output logic [31:0]               ahb_m0_haddr_o,
  output logic                      ahb_m0_hwrite_o,
  output logic [2:0]                ahb_m0_hsize_o,
  output logic [2:0]                ahb_m0_hburst_o,
  output logic [3:0]                ahb_m0_hprot_o,
  output logic [1:0]                ahb_m0_htrans_o,
  output logic                      ahb_m0_hmastlock_o,
  output logic [31:0]               ahb_m0_hwdata_o,
  input  logic                      ahb_m0_hready_i,
  input  logic                      ahb_m0_hresp_i,
  output logic [4:0]                class_o,
  output logic                      class_valid_o,
  output logic                      err_o
);
  import asl_pkg::*;

  wr_state_t   state_q, state_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [4:0]  result_q, result_d;
  logic [4:0]  class_q, class_d;
  logic        class_valid_q, class_valid_d;
  logic        err_q, err_d;

  logic        beat;
  logic        frame_done;
  logic [4:0]  am_result;
  logic        count_err;

  assign score_ready_o = (state_q == COLLECT);
  assign beat          = score_valid_i & score_ready_o;

  asl_argmax #(
    .NUM_CLASSES (NUM_CLASSES),
    .SCORE_W     (SCORE_W),
    .CONF_THRESH (CONF_THRESH)
  ) u_argmax (
    .clk          (clk),
    .resetn       (resetn),
    .beat_i       (beat),
    .score_i      (score_data_i),
    .last_i       (score_last_i),
    .frame_done_o (frame_done),
    .result_o     (am_result),
    .count_err_o  (count_err)
  );

  always_comb begin
    state_d       = state_q;
    htrans_d      = htrans_q;
    haddr_d       = haddr_q;
    hwrite_d      = hwrite_q;
    hwdata_d      = hwdata_q;
    result_d      = result_q;
    class_d       = class_q;
    class_valid_d = 1'b0;
    err_d         = err_q;
    unique case (state_q)
      COLLECT: begin
        if (frame_done) begin
          result_d = am_result;
          err_d    = err_q | count_err;
          state_d  = A0;
          htrans_d = HTRANS_NSEQ;
          haddr_d  = BASE_ADDR + SSD_DATA_OFS;
          hwrite_d = 1'b1;
        end
      end
      A0: begin
        if (ahb_m0_hready_i) begin
          state_d  = D0;
          htrans_d = HTRANS_IDLE;
          hwdata_d = {27'd0, result_q};
        end
      end
      D0: begin
        err_d = err_q | ahb_m0_hresp_i;
        if (ahb_m0_hready_i) begin
          state_d  = A1;
          htrans_d = HTRANS_NSEQ;
          haddr_d  = BASE_ADDR + SSD_DONE_OFS;
          hwrite_d = 1'b1;
        end
      end
      A1: begin
        if (ahb_m0_hready_i) begin
          state_d  = D1;
          htrans_d = HTRANS_IDLE;
          hwdata_d = 32'h0000_0001;
        end
      end
      D1: begin
        err_d = err_q | ahb_m0_hresp_i;
        if (ahb_m0_hready_i) begin
          // Done write completed: publish the class and return the bus to its idle values.
          state_d       = COLLECT;
          class_d       = result_q;
          class_valid_d = 1'b1;
          haddr_d       = 32'd0;
          hwrite_d      = 1'b0;
          hwdata_d      = 32'd0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= COLLECT;
      htrans_q      <= HTRANS_IDLE;
      haddr_q       <= 32'd0;
      hwrite_q      <= 1'b0;
      hwdata_q      <= 32'd0;
      result_q      <= CLASS_INVALID;
      class_q       <= CLASS_INVALID;
      class_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      htrans_q      <= htrans_d;
      haddr_q       <= haddr_d;
      hwrite_q      <= hwrite_d;
      hwdata_q      <= hwdata_d;
      result_q      <= result_d;
      class_q       <= class_d;
      class_valid_q <= class_valid_d;
      err_q         <= err_d;
    end
  end

  assign ahb_m0_haddr_o     = haddr_q;
  assign ahb_m0_hwrite_o    = hwrite_q;
  assign ahb_m0_hsize_o     = 3'b010;
  assign ahb_m0_hburst_o    = 3'b000;
  assign ahb_m0_hprot_o     = 4'b0011;
  assign ahb_m0_htrans_o    = htrans_q;
  assign ahb_m0_hmastlock_o = 1'b0;
  assign ahb_m0_hwdata_o    = hwdata_q;
  assign class_o            = class_q;
  assign class_valid_o      = class_valid_q;
  assign err_o              = err_q;

endmodule
